// File: rtl/sdram_copy_pkg.sv
// Shared types and constants for the SDRAM block copier.
package sdram_copy_pkg;

   typedef enum logic [2:0] {
      IDLE,
      LAUNCH,
      XFER,
      DRAIN,
      FINISH
   } state_e;

   localparam int unsigned WORD_BYTES = 4;
   localparam int unsigned WORD_SHIFT = $clog2(WORD_BYTES);

endpackage

// File: rtl/copy_hold_reg.sv
// One-entry holding register between the read and write user buffers.
// A load (pop from the read side) always wins over an unload (push) in the same cycle.
module copy_hold_reg #(
   parameter int unsigned DATAWIDTH = 32
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 load,
   input  logic                 unload,
   input  logic [DATAWIDTH-1:0] load_data,
   output logic                 valid,
   output logic [DATAWIDTH-1:0] data
);

   logic                 valid_q, valid_d;
   logic [DATAWIDTH-1:0] data_q, data_d;

   always_comb begin
      valid_d = valid_q;
      data_d  = data_q;
      if (load) begin
         valid_d = 1'b1;
         data_d  = load_data;
      end else if (unload) begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         valid_q <= 1'b0;
         data_q  <= '0;
      end else begin
         valid_q <= valid_d;
         data_q  <= data_d;
      end
   end

   assign valid = valid_q;
   assign data  = data_q;

endmodule

// File: rtl/sdram_block_copier.sv
// Copy engine that streams words from the read master buffer to the write master
// buffer through a one-entry holding register, summing the copied data.
module sdram_block_copier
   import sdram_copy_pkg::*;
#(
   parameter int unsigned ADDRESSWIDTH = 8,
   parameter int unsigned DATAWIDTH    = 32
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    start,
   input  logic [ADDRESSWIDTH-1:0] src_base,
   input  logic [ADDRESSWIDTH-1:0] dst_base,
   input  logic [ADDRESSWIDTH-1:0] byte_len,
   output logic                    busy,
   output logic                    done,
   output logic [DATAWIDTH-1:0]    checksum,
   output logic [ADDRESSWIDTH-1:0] words_moved,
   output logic                    rd_fixed_location,
   output logic [ADDRESSWIDTH-1:0] rd_base,
   output logic [ADDRESSWIDTH-1:0] rd_length,
   output logic                    rd_go,
   input  logic                    rd_done,
   output logic                    rd_buffer,
   input  logic [DATAWIDTH-1:0]    rd_buffer_data,
   input  logic                    rd_data_available,
   output logic                    wr_fixed_location,
   output logic [ADDRESSWIDTH-1:0] wr_base,
   output logic [ADDRESSWIDTH-1:0] wr_length,
   output logic                    wr_go,
   input  logic                    wr_done,
   output logic                    wr_buffer,
   output logic [DATAWIDTH-1:0]    wr_buffer_data,
   input  logic                    wr_buffer_full
);

   localparam int unsigned AW = ADDRESSWIDTH;
   localparam int unsigned DW = DATAWIDTH;

   state_e          state_q, state_d;
   logic            busy_q, busy_d;
   logic            done_q, done_d;
   logic            go_q, go_d;
   logic            rd_seen_q, rd_seen_d;
   logic            wr_seen_q, wr_seen_d;
   logic [DW-1:0]   checksum_q, checksum_d;
   logic [AW-1:0]   words_q, words_d;
   logic [AW-1:0]   popped_q, popped_d;
   logic [AW-1:0]   total_q, total_d;
   logic [AW-1:0]   rd_base_q, rd_base_d;
   logic [AW-1:0]   wr_base_q, wr_base_d;
   logic [AW-1:0]   len_q, len_d;

   logic            hold_valid;
   logic [DW-1:0]   hold_data;
   logic            pop_c, push_c;
   logic [AW-1:0]   start_words;

   assign start_words = AW'(byte_len >> WORD_SHIFT);

   // Strobes are gated by reset so an abort drops them in the cycle it is sampled.
   assign push_c = (state_q == XFER) & hold_valid & ~wr_buffer_full & ~reset;
   assign pop_c  = (state_q == XFER) & rd_data_available & (~hold_valid | push_c)
                 & (popped_q < total_q) & ~reset;

   copy_hold_reg #(
      .DATAWIDTH (DW)
   ) u_hold (
      .clk       (clk),
      .reset     (reset),
      .load      (pop_c),
      .unload    (push_c),
      .load_data (rd_buffer_data),
      .valid     (hold_valid),
      .data      (hold_data)
   );

   always_comb begin
      state_d    = state_q;
      busy_d     = busy_q;
      done_d     = 1'b0;
      go_d       = 1'b0;
      rd_seen_d  = rd_seen_q;
      wr_seen_d  = wr_seen_q;
      checksum_d = checksum_q;
      words_d    = words_q;
      popped_d   = popped_q;
      total_d    = total_q;
      rd_base_d  = rd_base_q;
      wr_base_d  = wr_base_q;
      len_d      = len_q;

      if (pop_c) begin
         checksum_d = checksum_q + rd_buffer_data;
         popped_d   = popped_q + AW'(1);
      end
      if (push_c) begin
         words_d = words_q + AW'(1);
      end
      if (busy_q & rd_done) rd_seen_d = 1'b1;
      if (busy_q & wr_done) wr_seen_d = 1'b1;
      // busy stays up through the done cycle and drops right after it
      if (done_q) busy_d = 1'b0;

      case (state_q)
         IDLE: begin
            if (start & ~busy_q) begin
               rd_base_d  = src_base;
               wr_base_d  = dst_base;
               len_d      = byte_len & ~AW'(WORD_BYTES - 1);
               total_d    = start_words;
               checksum_d = '0;
               words_d    = '0;
               popped_d   = '0;
               rd_seen_d  = 1'b0;
               wr_seen_d  = 1'b0;
               busy_d     = 1'b1;
               if (start_words == '0) begin
                  state_d = FINISH;
               end else begin
                  state_d = LAUNCH;
                  go_d    = 1'b1;
               end
            end
         end
         LAUNCH: state_d = XFER;
         XFER: begin
            if (words_d == total_q) state_d = DRAIN;
         end
         DRAIN: begin
            if ((rd_seen_q | rd_done) & (wr_seen_q | wr_done)) state_d = FINISH;
         end
         FINISH: begin
            done_d  = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= IDLE;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         go_q       <= 1'b0;
         rd_seen_q  <= 1'b0;
         wr_seen_q  <= 1'b0;
         checksum_q <= '0;
         words_q    <= '0;
         popped_q   <= '0;
         total_q    <= '0;
         rd_base_q  <= '0;
         wr_base_q  <= '0;
         len_q      <= '0;
      end else begin
         state_q    <= state_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         go_q       <= go_d;
         rd_seen_q  <= rd_seen_d;
         wr_seen_q  <= wr_seen_d;
         checksum_q <= checksum_d;
         words_q    <= words_d;
         popped_q   <= popped_d;
         total_q    <= total_d;
         rd_base_q  <= rd_base_d;
         wr_base_q  <= wr_base_d;
         len_q      <= len_d;
      end
   end

   assign busy              = busy_q;
   assign done              = done_q;
   assign checksum          = checksum_q;
   assign words_moved       = words_q;
   assign rd_fixed_location = 1'b0;
   assign wr_fixed_location = 1'b0;
   assign rd_base           = rd_base_q;
   assign wr_base           = wr_base_q;
   assign rd_length         = len_q;
   assign wr_length         = len_q;
   assign rd_go             = go_q;
   assign wr_go             = go_q;
   assign rd_buffer         = pop_c;
   assign wr_buffer         = push_c;
   assign wr_buffer_data    = hold_data;

endmodule

// File: tb/tb_sdram_block_copier.sv
// Bench for sdram_block_copier: read-buffer model, write-side scoreboard and directed copies.
module tb_sdram_block_copier;

   localparam int unsigned AW = 8;
   localparam int unsigned DW = 32;

   logic          clk = 1'b0;
   logic          reset, start;
   logic [AW-1:0] src_base, dst_base, byte_len;
   logic          busy, done;
   logic [DW-1:0] checksum;
   logic [AW-1:0] words_moved;
   logic          rd_fixed_location, rd_go, rd_done, rd_buffer, rd_data_available;
   logic [AW-1:0] rd_base, rd_length;
   logic [DW-1:0] rd_buffer_data;
   logic          wr_fixed_location, wr_go, wr_done, wr_buffer, wr_buffer_full;
   logic [AW-1:0] wr_base, wr_length;
   logic [DW-1:0] wr_buffer_data;

   int          n_checks = 0;
   int          n_fail   = 0;
   logic [DW-1:0] rd_fifo[$];
   logic [DW-1:0] exp_q[$];
   logic [DW-1:0] tmp_word;
   bit          pop_seen = 1'b0;
   bit          starve   = 1'b0;
   int unsigned cyc      = 0;
   int          rd_go_cnt, wr_go_cnt, done_cnt, push_cnt, pop_cnt;

   always #5 clk = ~clk;

   sdram_block_copier #(
      .ADDRESSWIDTH (AW),
      .DATAWIDTH    (DW)
   ) dut (
      .clk               (clk),
      .reset             (reset),
      .start             (start),
      .src_base          (src_base),
      .dst_base          (dst_base),
      .byte_len          (byte_len),
      .busy              (busy),
      .done              (done),
      .checksum          (checksum),
      .words_moved       (words_moved),
      .rd_fixed_location (rd_fixed_location),
      .rd_base           (rd_base),
      .rd_length         (rd_length),
      .rd_go             (rd_go),
      .rd_done           (rd_done),
      .rd_buffer         (rd_buffer),
      .rd_buffer_data    (rd_buffer_data),
      .rd_data_available (rd_data_available),
      .wr_fixed_location (wr_fixed_location),
      .wr_base           (wr_base),
      .wr_length         (wr_length),
      .wr_go             (wr_go),
      .wr_done           (wr_done),
      .wr_buffer         (wr_buffer),
      .wr_buffer_data    (wr_buffer_data),
      .wr_buffer_full    (wr_buffer_full)
   );

   task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Monitor: samples strobes mid-cycle and scores every push against the expected queue.
   always @(negedge clk) begin
      pop_seen = rd_buffer;
      if (rd_buffer) begin
         pop_cnt++;
         check("pop_needs_avail", DW'(rd_data_available), DW'(1));
      end
      if (rd_go) rd_go_cnt++;
      if (wr_go) wr_go_cnt++;
      if (done)  done_cnt++;
      if (wr_buffer) begin
         push_cnt++;
         check("push_while_full", DW'(wr_buffer_full), DW'(0));
         if (exp_q.size() == 0) check("push_unexpected", DW'(1), DW'(0));
         else                   check("push_data", wr_buffer_data, exp_q.pop_front());
      end
   end

   // Read user buffer model: retires the popped head word just after the edge.
   always @(posedge clk) begin
      #1;
      if (pop_seen && rd_fifo.size() > 0) tmp_word = rd_fifo.pop_front();
      pop_seen = 1'b0;
      cyc++;
      rd_data_available = (rd_fifo.size() > 0) && (!starve || cyc[0]);
      rd_buffer_data    = (rd_fifo.size() > 0) ? rd_fifo[0] : '0;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic load(input logic [DW-1:0] w, input bit expected);
      rd_fifo.push_back(w);
      if (expected) exp_q.push_back(w);
   endtask

   task automatic clear_counts();
      rd_go_cnt = 0; wr_go_cnt = 0; done_cnt = 0; push_cnt = 0; pop_cnt = 0;
   endtask

   task automatic start_copy(input logic [AW-1:0] src, input logic [AW-1:0] dst,
                             input logic [AW-1:0] len);
      tick();
      src_base = src; dst_base = dst; byte_len = len; start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic check_zero(input string tag);
      check({tag, "_busy"},  DW'(busy), '0);
      check({tag, "_done"},  DW'(done), '0);
      check({tag, "_csum"},  checksum, '0);
      check({tag, "_moved"}, DW'(words_moved), '0);
      check({tag, "_gos"},   DW'({rd_go, wr_go, rd_buffer, wr_buffer}), '0);
      check({tag, "_fixed"}, DW'({rd_fixed_location, wr_fixed_location}), '0);
      check({tag, "_bases"}, DW'({rd_base, wr_base, rd_length, wr_length}), '0);
      check({tag, "_wdata"}, wr_buffer_data, '0);
   endtask

   task automatic wait_moved(input logic [AW-1:0] n);
      int i = 0;
      while (words_moved !== n && i < 300) begin
         @(negedge clk);
         i++;
      end
      check("moved_reached", DW'(words_moved), DW'(n));
   endtask

   // Completes a copy: both master dones in separate cycles, then checks the result.
   task automatic finish_copy(input int nw, input logic [DW-1:0] csum);
      int i = 0;
      wait_moved(AW'(nw));
      tick();
      wr_done = 1'b1;
      tick();
      wr_done = 1'b0;
      tick();
      tick();
      rd_done = 1'b1;
      tick();
      rd_done = 1'b0;
      while (done !== 1'b1 && i < 300) begin
         @(negedge clk);
         i++;
      end
      check("done_seen", DW'(done), DW'(1));
      @(negedge clk);
      check("busy_after_done", DW'({busy, done}), DW'(0));
      tick();
      check("rd_go_pulses", DW'(rd_go_cnt), DW'(1));
      check("wr_go_pulses", DW'(wr_go_cnt), DW'(1));
      check("done_pulses",  DW'(done_cnt),  DW'(1));
      check("push_count",   DW'(push_cnt),  DW'(nw));
      check("words_moved",  DW'(words_moved), DW'(nw));
      check("checksum",     checksum, csum);
      check("sb_empty",     DW'(exp_q.size()), DW'(0));
   endtask

   initial begin
      reset = 1'b1; start = 1'b0; src_base = '0; dst_base = '0; byte_len = '0;
      rd_done = 1'b0; wr_done = 1'b0; wr_buffer_full = 1'b0;
      rd_data_available = 1'b0; rd_buffer_data = '0;
      clear_counts();
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_zero("reset");
      tick();
      reset = 1'b0;

      // Plain 4-word copy
      @(negedge clk);
      clear_counts();
      for (int i = 1; i <= 4; i++) load(DW'(i), 1'b1);
      start_copy(8'h00, 8'h40, 8'd16);
      @(negedge clk);
      check("t1_lengths", DW'({rd_length, wr_length}), DW'({8'd16, 8'd16}));
      check("t1_bases",   DW'({rd_base, wr_base}), DW'({8'h00, 8'h40}));
      check("t1_busy",    DW'(busy), DW'(1));
      finish_copy(4, 32'd10);

      // Write backpressure for 5 cycles mid-transfer
      @(negedge clk);
      clear_counts();
      for (int i = 1; i <= 4; i++) load(DW'(i), 1'b1);
      start_copy(8'h00, 8'h40, 8'd16);
      wait_moved(8'd1);
      tick();
      wr_buffer_full = 1'b1;
      repeat (5) tick();
      check("bp_one_held", DW'(pop_cnt - push_cnt), DW'(1));
      wr_buffer_full = 1'b0;
      finish_copy(4, 32'd10);

      // Read starvation: data available every other cycle
      @(negedge clk);
      clear_counts();
      starve = 1'b1;
      for (int i = 5; i <= 8; i++) load(DW'(i), 1'b1);
      start_copy(8'h10, 8'h80, 8'd16);
      finish_copy(4, 32'd26);
      starve = 1'b0;

      // Zero-length copy: no go pulses, done two cycles after start
      @(negedge clk);
      clear_counts();
      start_copy(8'h04, 8'h08, 8'd3);
      @(negedge clk);
      check("z_cyc1", DW'({busy, done}), DW'(2'b10));
      @(negedge clk);
      check("z_cyc2", DW'({busy, done}), DW'(2'b11));
      @(negedge clk);
      check("z_cyc3", DW'({busy, done}), DW'(2'b00));
      tick();
      check("z_gos",      DW'(rd_go_cnt + wr_go_cnt), DW'(0));
      check("z_checksum", checksum, '0);
      check("z_lengths",  DW'({rd_length, wr_length}), DW'(0));

      // 7-byte copy: one word moved, excess source word left unpopped
      @(negedge clk);
      clear_counts();
      load(32'h0000_00A5, 1'b1);
      load(32'h0000_005A, 1'b0);
      start_copy(8'h20, 8'h30, 8'd7);
      @(negedge clk);
      check("s_lengths", DW'({rd_length, wr_length}), DW'({8'd4, 8'd4}));
      finish_copy(1, 32'hA5);
      check("s_excess_left", DW'(rd_fifo.size()), DW'(1));
      @(negedge clk);
      rd_fifo.delete();

      // Start while busy is ignored; checksum wraps
      @(negedge clk);
      clear_counts();
      wr_buffer_full = 1'b1;
      load(32'hFFFF_FFFF, 1'b1);
      load(32'h0000_0002, 1'b1);
      start_copy(8'h10, 8'h50, 8'd8);
      repeat (3) tick();
      start_copy(8'h80, 8'h90, 8'd16);
      @(negedge clk);
      check("sb_len_kept",  DW'(rd_length), DW'(8));
      check("sb_base_kept", DW'({rd_base, wr_base}), DW'({8'h10, 8'h50}));
      wr_buffer_full = 1'b0;
      finish_copy(2, 32'd1);

      // Reset mid-transfer, then a normal 1-word copy
      @(negedge clk);
      clear_counts();
      for (int i = 0; i < 4; i++) load(DW'(32'h11 * (i + 1)), 1'b1);
      start_copy(8'h00, 8'h00, 8'd16);
      wait_moved(8'd2);
      tick();
      reset = 1'b1;
      tick();
      @(negedge clk);
      check_zero("rst_mid");
      tick();
      reset = 1'b0;
      @(negedge clk);
      rd_fifo.delete();
      exp_q.delete();
      clear_counts();
      load(32'h0000_1234, 1'b1);
      start_copy(8'h04, 8'h08, 8'd4);
      finish_copy(1, 32'h1234);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/sdram_block_copier.md
Name: sdram_block_copier

Overview:
- Copy engine that sits between the Avalon-MM read master and write master of the SDRAM/PCIe subsystem.
- It consumes words from the read master's user buffer and feeds them, through a 1-deep holding register, into the write master's user buffer.
- It drives both masters' control ports (base, length, go; done returned) and accumulates a running checksum of the copied data.
- A user controller starts a copy with a single start pulse and receives done plus the checksum.

Parameters:
ADDRESSWIDTH, 8, width of base/length/count signals (byte addressing)
DATAWIDTH, 32, word width; the bytes-per-word constant is DATAWIDTH/8 = 4

Ports:
clk  in  1  system clock
reset  in  1  synchronous reset, active-high
start  in  1  one-cycle request to begin a copy
src_base  in  ADDRESSWIDTH  source byte address (word aligned)
dst_base  in  ADDRESSWIDTH  destination byte address (word aligned)
byte_len  in  ADDRESSWIDTH  copy length in bytes; bits [1:0] are ignored
busy  out  1  high from accepted start until done
done  out  1  one-cycle pulse at completion
checksum  out  DATAWIDTH  sum mod 2^DATAWIDTH of all copied words; held until next start
words_moved  out  ADDRESSWIDTH  count of words pushed to the write master
rd_fixed_location  out  1  tied 0
rd_base  out  ADDRESSWIDTH  latched src_base
rd_length  out  ADDRESSWIDTH  latched byte_len & ~3
rd_go  out  1  one-cycle go pulse
rd_done  in  1  read master complete
rd_buffer  out  1  pop strobe to the read user buffer
rd_buffer_data  in  DATAWIDTH  head word of the read buffer
rd_data_available  in  1  read buffer is non-empty
wr_fixed_location  out  1  tied 0
wr_base  out  ADDRESSWIDTH  latched dst_base
wr_length  out  ADDRESSWIDTH  latched byte_len & ~3
wr_go  out  1  one-cycle go pulse
wr_done  in  1  write master complete
wr_buffer  out  1  push strobe to the write user buffer
wr_buffer_data  out  DATAWIDTH  holding-register data
wr_buffer_full  in  1  write buffer is full

Behaviour:
- Reset values: all outputs 0; state IDLE; holding register empty. Reset mid-copy aborts immediately; go/strobes drop in the same cycle reset is sampled.
- total_words = byte_len >> 2, latched together with src_base, dst_base and length on an accepted start. Base/length outputs are registered and stable while busy.
- IDLE:
  - On start: latch inputs, clear checksum and words_moved, set busy.
  - If total_words = 0, go to FINISH; neither go is pulsed.
  - Otherwise go to LAUNCH.
  - start is ignored while busy.
- LAUNCH: rd_go = wr_go = 1 for exactly one cycle, then XFER.
- XFER:
  - Pop condition: rd_buffer = rd_data_available & (hold empty | push this cycle) & (popped < total_words).
  - On pop: the hold register loads rd_buffer_data on the next edge, and checksum += rd_buffer_data (wraps mod 2^DATAWIDTH).
  - Push condition: wr_buffer = hold_valid & ~wr_buffer_full. On push, words_moved increments.
  - A simultaneous pop and push keeps hold_valid = 1, giving full throughput of 1 word/cycle and a 1-cycle latency from pop to push.
  - Once words_moved reaches total_words, go to DRAIN.
- DRAIN: wait until both rd_done and wr_done have been seen high (each flag is sticky within the copy, in any order or cycle), then FINISH.
- FINISH: done = 1 for one cycle, busy = 0 in the following cycle, return to IDLE. checksum and words_moved hold.
- Excess read data beyond total_words is never popped.
- wr_buffer and rd_buffer are never asserted outside XFER.
- Overflow: byte_len is at most 2^ADDRESSWIDTH-1, so words_moved cannot overflow.

Decomposition:
- Package sdram_copy_pkg holds the state enum (IDLE, LAUNCH, XFER, DRAIN, FINISH) and the WORD_BYTES = 4 constant.
- Sub-module copy_hold_reg is the 1-entry skid/holding register with a pop/push handshake and DATAWIDTH parameter. The FSM, counters and checksum stay in the top module.

Test Plan:
- Copy of 4 words: byte_len=16, src_base=8'h00, dst_base=8'h40, source words 1,2,3,4, no stalls -> one rd_go and one wr_go pulse, rd_length = wr_length = 16, four pushes carrying 1,2,3,4, checksum=10, words_moved=4, done one cycle after both rd_done and wr_done.
- Write backpressure: same copy with wr_buffer_full high for 5 cycles mid-transfer -> no push while full, at most one word held, no word lost or duplicated, checksum=10.
- Read starvation: rd_data_available toggling every other cycle -> rd_buffer asserted only when data is available, order preserved, words_moved=4.
- Zero/short length: byte_len=3 -> no go pulses, done two cycles after start, checksum=0. Also byte_len=7 -> lengths 4, one word copied.
- Start while busy and wrap: second start during XFER is ignored. Words 32'hFFFFFFFF and 2 give checksum=1.
- Reset mid-XFER after 2 words -> all outputs 0 on the next cycle, and a following 1-word copy completes normally.
